shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_seq_ctrl_bit_timer.sv | 33 +++
 rtl/shift_seq_ctrl.sv | 104 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the 4-bit load/shift register sequencer.
package shift_seq_pkg;

  localparam int REG_WIDTH = 4;
  localparam int BIT_IDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SETTLE,
    S_HOLD,
    S_STEP
  } seqState_t;

  // Cycles from the accepting edge to the edge that raises DONE.
  function automatic int frameLen(input int bitCycles);
    return 3 + REG_WIDTH * bitCycles + (REG_WIDTH - 1);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_bit_timer.sv
// Saturating down-counter timing one serial bit window; tc is high at zero.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic tc
);

  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_ONE;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving D/LOAD/SHIFT of a 4-bit load/shift register to emit an
// MSB-first serial stream on its Q3 tap; every control pin comes from a flop.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH      = REG_WIDTH,
  parameter int BIT_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [WIDTH-1:0]     DIN,
  output logic                 READY,
  output logic [WIDTH-1:0]     D_OUT,
  output logic                 LOAD,
  output logic                 SHIFT,
  output logic                 BIT_VALID,
  output logic [BIT_IDX_W-1:0] BIT_IDX,
  output logic                 DONE
);

  localparam logic [BIT_IDX_W-1:0] IDX_FIRST = '1;
  localparam logic [BIT_IDX_W-1:0] IDX_ONE   = BIT_IDX_W'(1);

  seqState_t state;
  logic timerClr;
  logic timerLoad;
  logic timerDec;
  logic timerTc;

  // Timer is reloaded on the edge entering each HOLD window.
  assign timerClr  = (state == S_SETUP);
  assign timerLoad = (state == S_SETTLE) || (state == S_STEP);
  assign timerDec  = (state == S_HOLD);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) uTimer (
    .clk (CLK),
    .rst (RST),
    .clr (timerClr),
    .load(timerLoad),
    .dec (timerDec),
    .tc  (timerTc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      READY     <= 1'b1;
      D_OUT     <= '0;
      LOAD      <= 1'b0;
      SHIFT     <= 1'b0;
      BIT_VALID <= 1'b0;
      BIT_IDX   <= IDX_FIRST;
      DONE      <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      SHIFT <= 1'b0;
      LOAD  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            D_OUT <= DIN;
            READY <= 1'b0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          LOAD  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          BIT_IDX <= IDX_FIRST;
          state   <= S_SETTLE;
        end
        S_SETTLE: begin
          BIT_VALID <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (timerTc) begin
            BIT_VALID <= 1'b0;
            if (BIT_IDX == '0) begin
              READY <= 1'b1;
              DONE  <= 1'b1;
              state <= S_IDLE;
            end else begin
              SHIFT <= 1'b1;
              state <= S_STEP;
            end
          end
        end
        S_STEP: begin
          BIT_VALID <= 1'b1;
          BIT_IDX   <= BIT_IDX - IDX_ONE;
          state     <= S_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: two instances (BIT_CYCLES 4 and 1) plus a
// behavioural model of the downstream load/shift register to observe Q3.
module tb_shift_seq_ctrl;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int cur;
  logic startReq;
  logic [3:0] dinReq;

  logic start4, ready4, load4, shift4, valid4, done4;
  logic [3:0] din4, dout4;
  logic [1:0] idx4;
  logic start1, ready1, load1, shift1, valid1, done1;
  logic [3:0] din1, dout1;
  logic [1:0] idx1;

  assign start4 = (cur == 0) && startReq;
  assign start1 = (cur == 1) && startReq;
  assign din4   = dinReq;
  assign din1   = dinReq;

  shift_seq_ctrl #(.WIDTH(4), .BIT_CYCLES(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(start4), .DIN(din4), .READY(ready4),
    .D_OUT(dout4), .LOAD(load4), .SHIFT(shift4), .BIT_VALID(valid4),
    .BIT_IDX(idx4), .DONE(done4)
  );

  shift_seq_ctrl #(.WIDTH(4), .BIT_CYCLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(start1), .DIN(din1), .READY(ready1),
    .D_OUT(dout1), .LOAD(load1), .SHIFT(shift1), .BIT_VALID(valid1),
    .BIT_IDX(idx1), .DONE(done1)
  );

  // Behavioural 4-bit register: async parallel load, shift on SHIFT rising.
  logic [3:0] sreg4, sreg1;
  always @(posedge shift4 or posedge load4)
    if (load4) sreg4 <= dout4; else sreg4 <= {sreg4[2:0], 1'b0};
  always @(posedge shift1 or posedge load1)
    if (load1) sreg1 <= dout1; else sreg1 <= {sreg1[2:0], 1'b0};

  logic sReady, sLoad, sShift, sValid, sDone, sQ3;
  logic [3:0] sDout;
  logic [1:0] sIdx;
  always_comb begin
    sReady = ready4; sLoad = load4; sShift = shift4; sValid = valid4;
    sDone = done4; sDout = dout4; sIdx = idx4; sQ3 = sreg4[3];
    if (cur == 1) begin
      sReady = ready1; sLoad = load1; sShift = shift1; sValid = valid1;
      sDone = done1; sDout = dout1; sIdx = idx1; sQ3 = sreg1[3];
    end
  end

  int nCmp = 0;
  int nErr = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Concurrency checker on the instance currently being exercised.
  logic prevShift = 1'b0;
  always @(negedge CLK) begin
    if (!RST) begin
      check("load_shift_overlap", {7'd0, sLoad && sShift}, 8'd0);
      if (sShift) check("shift_width", {7'd0, prevShift}, 8'd0);
    end
    prevShift <= sShift;
  end

  // Starts at the negedge of an idle period; period p counts clock periods
  // after the accepting edge, so DONE shows in period frameEdges+1.
  task automatic runFrame(input logic [3:0] w, input int bc, input int stopAt,
                          input bit holdStart, input bit disturb, input int expDoneEdge);
    int last, nShift, nValid, doneP;
    last   = 3 + 4 * bc + 3 + 1;
    nShift = 0;
    nValid = 0;
    doneP  = 0;
    startReq = 1'b1;
    dinReq   = w;
    check("ready_at_accept", {7'd0, sReady}, 8'd1);
    for (int p = 1; p <= last; p++) begin
      int q, bi, r;
      logic eLoad, eShift, eValid, eEnd;
      @(negedge CLK);
      q  = (p >= 4) ? p - 4 : 0;
      bi = q / (bc + 1);
      r  = q % (bc + 1);
      eEnd   = (p == last);
      eLoad  = (p == 2);
      eValid = (p >= 4) && !eEnd && (r < bc);
      eShift = (p >= 4) && !eEnd && (r == bc);
      check("load", {7'd0, sLoad}, {7'd0, eLoad});
      check("shift", {7'd0, sShift}, {7'd0, eShift});
      check("bit_valid", {7'd0, sValid}, {7'd0, eValid});
      check("done", {7'd0, sDone}, {7'd0, eEnd});
      check("ready", {7'd0, sReady}, {7'd0, eEnd});
      if (eValid) begin
        check("bit_idx", {6'd0, sIdx}, 8'(3 - bi));
        check("q3", {7'd0, sQ3}, {7'd0, w[3 - bi]});
        check("d_out", {4'd0, sDout}, {4'd0, w});
        nValid++;
      end
      if (sShift) nShift++;
      if (sDone && doneP == 0) doneP = p;
      if (p == stopAt) return;
      if (p == 1 && !holdStart) startReq = 1'b0;
      if (disturb && p == 5) begin startReq = 1'b1; dinReq = 4'hF; end
      if (disturb && p == 6) startReq = 1'b0;
    end
    check("shift_pulses", 8'(nShift), 8'd3);
    check("valid_cycles", 8'(nValid), 8'(4 * bc));
    check("done_edge", 8'(doneP - 1), 8'(expDoneEdge));
  endtask

  task automatic idleNoDone(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_no_done", {7'd0, sDone}, 8'd0);
      check("idle_ready", {7'd0, sReady}, 8'd1);
    end
  endtask

  task automatic resetMid(input string tag, input int stopAt);
    runFrame(4'b1010, 4, stopAt, 1'b0, 1'b0, 0);
    #2 RST = 1'b1;
    #1;
    check({tag, "_shift"}, {7'd0, shift4}, 8'd0);
    check({tag, "_load"}, {7'd0, load4}, 8'd0);
    check({tag, "_valid"}, {7'd0, valid4}, 8'd0);
    check({tag, "_ready"}, {7'd0, ready4}, 8'd1);
    check({tag, "_idx"}, {6'd0, idx4}, 8'd3);
    check({tag, "_done"}, {7'd0, done4}, 8'd0);
    @(negedge CLK);
    RST = 1'b0;
    idleNoDone(4);
  endtask

  initial begin
    RST = 1'b1;
    cur = 0;
    startReq = 1'b0;
    dinReq = 4'h0;
    #1;
    for (int d = 0; d < 2; d++) begin
      cur = d;
      #1;
      check("rst_ready", {7'd0, sReady}, 8'd1);
      check("rst_load", {7'd0, sLoad}, 8'd0);
      check("rst_shift", {7'd0, sShift}, 8'd0);
      check("rst_valid", {7'd0, sValid}, 8'd0);
      check("rst_done", {7'd0, sDone}, 8'd0);
      check("rst_dout", {4'd0, sDout}, 8'd0);
      check("rst_idx", {6'd0, sIdx}, 8'd3);
    end
    cur = 0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Single frame 1010: LOAD in period 2, DONE 22 edges after accept.
    runFrame(4'b1010, 4, 0, 1'b0, 1'b0, 22);
    idleNoDone(3);

    // Back-to-back with START held: second accept in the DONE cycle.
    runFrame(4'b0001, 4, 0, 1'b1, 1'b0, 22);
    runFrame(4'b1110, 4, 0, 1'b0, 1'b0, 22);
    idleNoDone(3);

    // START and DIN disturbed mid-frame: ignored, single DONE.
    runFrame(4'h3, 4, 0, 1'b0, 1'b1, 22);
    idleNoDone(6);

    // Asynchronous reset during LOAD, mid-HOLD of bit 2, and during STEP.
    resetMid("rst_in_load", 2);
    resetMid("rst_in_hold2", 10);
    resetMid("rst_in_step", 8);

    // One-cycle bit windows.
    cur = 1;
    @(negedge CLK);
    runFrame(4'b0110, 1, 0, 1'b0, 1'b0, 10);
    idleNoDone(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
